// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle MIPS datapath (Moore outputs, pcen also uses zero).
// Define MAINDEC_BNE_EN to add the BNEEX state (code 12) for op 000101.
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MAINDEC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_q, state_d;
  state_t dec_s;

  logic pcwrite_s, branch_s, bne_s;
  logic memwrite_s, irwrite_s, regwrite_s;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MAINDEC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      // op is still the instruction's opcode here since irwrite only fires in FETCH
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // During reset the selects show their FETCH values regardless of the stored state
  assign dec_s = reset ? S_FETCH : state_q;

  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    bne_s      = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (dec_s)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcwrite_s = 1'b1;
        pcsrc     = 2'b10;
      end
`ifdef MAINDEC_BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne_s   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;

`ifdef MAINDEC_BNE_EN
  assign pcen = ~reset & (pcwrite_s | (branch_s & zero) | (bne_s & ~zero));
`else
  assign pcen = ~reset & (pcwrite_s | (branch_s & zero));
  logic unused_bne;
  assign unused_bne = bne_s;
`endif

  assign state = state_q;

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Main control finite state machine for the multicycle MIPS datapath. It issues the two-bit ALU operation class that the ALU decoder consumes, along with every register-enable and mux-select in the datapath. It steps each instruction through fetch, decode and execute states, and raises the PC enable from the branch condition. It sits between the instruction register (which supplies the opcode), the ALU (which supplies the zero flag), and the ALU decoder plus datapath enables.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction opcode field, bits 31:26 of the instruction register.
- zero  in  1  ALU zero flag.
- pcen  out  1  PC register enable: pcwrite | (branch & zero), plus the bne term when configured.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  register file write data: 0 = ALUOut, 1 = Data register.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  2  00 = add, 01 = subtract, 10 = decode by funct field, 11 = unused.
- state  out  4  current state code, for debug and verification.

## Operation
- Moore machine: 4-bit state register; every output decodes from state only. pcen is the one exception, since it also combines zero.
- State codes and the outputs each state asserts (any output not listed is 0):
  - 0 FETCH: irwrite, pcwrite, alusrcb=01, aluop=00, pcsrc=00.
  - 1 DECODE: alusrcb=11, aluop=00.
  - 2 MEMADR: alusrca, alusrcb=10.
  - 3 MEMRD: iord.
  - 4 MEMWB: regwrite, memtoreg, regdst=0.
  - 5 MEMWR: iord, memwrite.
  - 6 RTYPEEX: alusrca, alusrcb=00, aluop=10.
  - 7 RTYPEWB: regwrite, regdst=1, memtoreg=0.
  - 8 BEQEX: alusrca, alusrcb=00, aluop=01, pcsrc=01, branch.
  - 9 ADDIEX: alusrca, alusrcb=10, aluop=00.
  - 10 ADDIWB: regwrite, regdst=0, memtoreg=0.
  - 11 JEX: pcwrite, pcsrc=10.
- Transitions:
  - FETCH→DECODE.
  - DECODE→ by op: 100011 lw and 101011 sw→MEMADR; 000000 R-type→RTYPEEX; 000100 beq→BEQEX; 001000 addi→ADDIEX; 000010 j→JEX.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX each →FETCH.
- MEMADR selects between MEMRD and MEMWR using op as sampled in that cycle; op is held stable because irwrite is 0 outside FETCH.
- Unrecognised opcode in DECODE: next state FETCH. No register, memory or PC write occurs for that instruction.
- Unused state codes 12–15 (13–15 when the bne feature is compiled in): all outputs 0, next state FETCH.
- branch is an internal signal only and is not a port.

## Timing
- Reset: at the rising edge with reset=1, state becomes FETCH.
  - While reset=1, pcen, irwrite, memwrite and regwrite are forced to 0.
  - Mux selects and aluop take their FETCH values throughout reset.
- Reset asserted mid-instruction aborts that instruction. Write strobes are suppressed in the reset cycle, and FETCH follows the edge.
- Instruction latency in cycles from FETCH to the next FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unknown opcode: 2
- pcen responds combinationally to zero in BEQEX; the PC updates at the end of that cycle.
- memwrite and regwrite are single-cycle pulses, asserted in exactly one state per instruction.

## Configuration
- MAINDEC_BNE_EN defined:
  - DECODE op 000101 goes to state 12 BNEEX.
  - BNEEX outputs match BEQEX except that branch is replaced by bne.
  - pcen = pcwrite | (branch & zero) | (bne & ~zero).
  - BNEEX→FETCH.
- Not defined:
  - op 000101 is treated as an unrecognised opcode: DECODE→FETCH.
  - State 12 behaves as an unused code.
  - pcen = pcwrite | (branch & zero).

## Test plan
- reset=1 for 2 cycles, then release → state=0, irwrite=1, pcwrite=1, alusrcb=01 in the first cycle after release; pcen=0 while reset=1.
- op=100011 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 only in state 3.
- op=101011 → sequence 0,1,2,5,0; memwrite=1 only in state 5; regwrite never asserted.
- op=000000 → sequence 0,1,6,7,0 with aluop=10 in state 6 and regdst=1 in state 7. op=001000 → sequence 0,1,9,10,0 with alusrcb=10 in state 9.
- op=000100 in BEQEX: zero=1 → pcen=1, pcsrc=01, aluop=01; zero=0 → pcen=0. op=000101 → pcen=1 exactly when zero=0 with MAINDEC_BNE_EN defined; sequence 0,1,0 without it.
- op=000010 → sequence 0,1,11,0 with pcsrc=10 and pcen=1 in state 11. op=111111 → sequence 0,1,0. Reset asserted in state 3 → next state 0 and no regwrite.
